bp_sacc_dma_fetch: RTL and testbench

BP_SACC_DMA_FETCH -- requirements
Module: bp_sacc_dma_fetch

---
 rtl/bp_sacc_dma_fetch.sv | 192 +++++++++++++++++++
 tb/tb_bp_sacc_dma_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_sacc_dma_fetch.sv
// Scratchpad DMA fetch engine: streams length_i 64-bit reads from base_addr_i into a scratchpad.
// Optional bounds check on start (error_o port) is enabled by defining BP_SACC_DMA_BOUNDS_CHECK_EN.
module bp_sacc_dma_fetch #(
    parameter int paddr_width_p     = 40,
    parameter int spm_els_p         = 4096,
    parameter int max_outstanding_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [paddr_width_p-1:0]      base_addr_i,
    input  logic [15:0]                   length_i,
    input  logic [1:0]                    spm_sel_i,
    output logic                          busy_o,
    output logic                          done_o,
`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
    output logic                          error_o,
`endif
    output logic                          cmd_v_o,
    output logic [paddr_width_p-1:0]      cmd_addr_o,
    input  logic                          cmd_yumi_i,
    input  logic                          resp_v_i,
    input  logic [63:0]                   resp_data_i,
    output logic                          resp_ready_o,
    output logic                          spm_w_v_o,
    output logic [1:0]                    spm_sel_o,
    output logic [$clog2(spm_els_p)-1:0]  spm_addr_o,
    output logic [63:0]                   spm_data_o
);

    localparam int spm_idx_w_lp = $clog2(spm_els_p);
    localparam int out_w_lp     = $clog2(max_outstanding_p + 1);
    localparam logic [out_w_lp-1:0] out_max_lp = out_w_lp'(max_outstanding_p);
    localparam logic [31:0] spm_els_lp = 32'(spm_els_p);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                     state_r;
    state_e                     state_s;
    logic [paddr_width_p-1:0]   base_r;
    logic [15:0]                length_r;
    logic [1:0]                 sel_r;
    logic [15:0]                issued_r;
    logic [15:0]                received_r;
    logic [out_w_lp-1:0]        outst_r;
    logic                       done_r;
    logic                       error_r;

    logic                       start_acc_s;
    logic                       start_err_s;
    logic                       bounds_err_s;
    logic                       cmd_v_s;
    logic                       yumi_acc_s;
    logic                       resp_acc_s;
    logic [paddr_width_p-1:0]   offset_s;

`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
    assign bounds_err_s = ({16'd0, length_i} > spm_els_lp);
    assign error_o      = error_r;
`else
    assign bounds_err_s = 1'b0;
`endif

    assign cmd_v_s    = (state_r == ISSUE) && (outst_r < out_max_lp) && (issued_r != length_r);
    assign yumi_acc_s = cmd_yumi_i && cmd_v_s;
    // Responses outside an active transfer (including stragglers after reset) are dropped.
    assign resp_acc_s = resp_v_i && ((state_r == ISSUE) || (state_r == DRAIN));
    assign offset_s   = paddr_width_p'({issued_r, 3'b000});

    // Next-state and start-acceptance decode.
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        start_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i && bounds_err_s) begin
                    start_err_s = 1'b1;
                    state_s     = IDLE;
                end else if (start_i) begin
                    start_acc_s = 1'b1;
                    state_s     = (length_i == 16'd0) ? DONE : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (yumi_acc_s && ((issued_r + 16'd1) == length_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (received_r == length_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transfer descriptor latched on an accepted start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            base_r   <= {paddr_width_p{1'b0}};
            length_r <= 16'd0;
            sel_r    <= 2'd0;
        end else if (start_acc_s) begin
            base_r   <= base_addr_i;
            length_r <= length_i;
            sel_r    <= spm_sel_i;
        end
    end

    // Issued / received / outstanding bookkeeping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            issued_r   <= 16'd0;
            received_r <= 16'd0;
            outst_r    <= {out_w_lp{1'b0}};
        end else if (start_acc_s) begin
            issued_r   <= 16'd0;
            received_r <= 16'd0;
            outst_r    <= {out_w_lp{1'b0}};
        end else begin
            if (yumi_acc_s) begin
                issued_r <= issued_r + 16'd1;
            end
            if (resp_acc_s) begin
                received_r <= received_r + 16'd1;
            end
            case ({yumi_acc_s, resp_acc_s})
                2'b10:   outst_r <= outst_r + {{(out_w_lp-1){1'b0}}, 1'b1};
                2'b01:   outst_r <= (outst_r != {out_w_lp{1'b0}}) ? (outst_r - {{(out_w_lp-1){1'b0}}, 1'b1}) : outst_r;
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Sticky completion and bounds-error flags; setting done wins over the clearing start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            if ((state_s == DONE) && (state_r != DONE)) begin
                done_r <= 1'b1;
            end else if (start_acc_s) begin
                done_r <= 1'b0;
            end
            if (start_err_s) begin
                error_r <= 1'b1;
            end else if (start_acc_s) begin
                error_r <= 1'b0;
            end
        end
    end

    assign busy_o       = (state_r == ISSUE) || (state_r == DRAIN);
    assign done_o       = done_r;
    assign cmd_v_o      = cmd_v_s;
    assign cmd_addr_o   = base_r + offset_s;
    assign resp_ready_o = 1'b1;
    assign spm_w_v_o    = resp_acc_s;
    assign spm_sel_o    = resp_acc_s ? sel_r : 2'd0;
    assign spm_addr_o   = resp_acc_s ? received_r[spm_idx_w_lp-1:0] : {spm_idx_w_lp{1'b0}};
    assign spm_data_o   = resp_acc_s ? resp_data_i : 64'd0;

`ifndef BP_SACC_DMA_BOUNDS_CHECK_EN
    logic unused_s;
    assign unused_s = error_r ^ start_err_s ^ (|spm_els_lp);
`endif

endmodule

// File: tb/tb_bp_sacc_dma_fetch.sv
// Directed self-checking bench for bp_sacc_dma_fetch (default parameters).
`timescale 1ns/1ps
module tb_bp_sacc_dma_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [39:0] base_addr = 40'd0;
    logic [15:0] length = 16'd0;
    logic [1:0]  spm_sel = 2'd0;
    logic        busy;
    logic        done;
`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
    logic        error;
`endif
    logic        cmd_v;
    logic [39:0] cmd_addr;
    logic        cmd_yumi = 1'b0;
    logic        resp_v = 1'b0;
    logic [63:0] resp_data = 64'd0;
    logic        resp_ready;
    logic        spm_w_v;
    logic [1:0]  spm_sel_o;
    logic [11:0] spm_addr;
    logic [63:0] spm_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_sacc_dma_fetch dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .base_addr_i(base_addr),
        .length_i(length), .spm_sel_i(spm_sel), .busy_o(busy), .done_o(done),
`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
        .error_o(error),
`endif
        .cmd_v_o(cmd_v), .cmd_addr_o(cmd_addr), .cmd_yumi_i(cmd_yumi),
        .resp_v_i(resp_v), .resp_data_i(resp_data), .resp_ready_o(resp_ready),
        .spm_w_v_o(spm_w_v), .spm_sel_o(spm_sel_o), .spm_addr_o(spm_addr), .spm_data_o(spm_data)
    );

    task automatic do_start(input logic [39:0] b, input logic [15:0] n, input logic [1:0] s);
        @(negedge clk);
        base_addr = b; length = n; spm_sel = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        resp_v = 1'b1; resp_data = 64'hDEAD_BEEF; cmd_yumi = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
        checks++; if (cmd_v !== 1'b0) begin failures++; $display("FAIL reset_cmd_v got=%0h exp=0", cmd_v); end
        checks++; if (cmd_addr !== 40'd0) begin failures++; $display("FAIL reset_cmd_addr got=%h exp=0", cmd_addr); end
        checks++; if (spm_w_v !== 1'b0) begin failures++; $display("FAIL reset_spm_w_v got=%0h exp=0", spm_w_v); end
        checks++; if ({spm_sel_o, spm_addr} !== 14'd0) begin failures++; $display("FAIL reset_spm_sel_addr got=%h exp=0", {spm_sel_o, spm_addr}); end
        checks++; if (spm_data !== 64'd0) begin failures++; $display("FAIL reset_spm_data got=%h exp=0", spm_data); end
        checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL reset_resp_ready got=%0h exp=1", resp_ready); end
`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0h exp=0", error); end
`endif
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (spm_w_v !== 1'b0) begin failures++; $display("FAIL idle_resp_drop got=%0h exp=0", spm_w_v); end
        checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL idle_resp_ready got=%0h exp=1", resp_ready); end
        resp_v = 1'b0;
    endtask

    task automatic test_basic;
        int due_q[$];
        int nis = 0, nrc = 0;
        bit fin = 1'b0;
        logic [39:0] b = 40'h00_8000_0000;
        logic [63:0] exp_d;
        do_start(b, 16'd4, 2'd2);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front()); resp_v = 1'b1; resp_data = 64'(nrc + 1) * 64'h11;
            end else begin
                resp_v = 1'b0;
            end
            #1;
            if (cmd_v) begin
                checks++; if (nis >= 4 || cmd_addr !== b + 40'(nis * 8)) begin failures++; $display("FAIL basic_addr got=%h exp=%h n=%0d", cmd_addr, b + 40'(nis * 8), nis); end
                cmd_yumi = 1'b1; due_q.push_back(cyc + 2); nis++;
            end else begin
                cmd_yumi = 1'b0;
            end
            if (resp_v) begin
                exp_d = 64'(nrc + 1) * 64'h11;
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'(nrc) || spm_data !== exp_d || spm_sel_o !== 2'd2)
                    begin failures++; $display("FAIL basic_write got=%0h/%0d/%h/%0d exp=1/%0d/%h/2", spm_w_v, spm_addr, spm_data, spm_sel_o, nrc, exp_d); end
                nrc++;
            end else begin
                checks++; if (spm_w_v !== 1'b0) begin failures++; $display("FAIL basic_no_write got=%0h exp=0", spm_w_v); end
            end
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        cmd_yumi = 1'b0; resp_v = 1'b0; #1;
        checks++; if (!fin) begin failures++; $display("FAIL basic_timeout got=0 exp=1"); end
        checks++; if (nis != 4 || nrc != 4) begin failures++; $display("FAIL basic_counts got=%0d/%0d exp=4/4", nis, nrc); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done_sticky got=%0h/%0h exp=1/0", done, busy); end
    endtask

    task automatic test_backpressure;
        int nis = 0, nrc = 1, outs = 4;
        bit fin = 1'b0;
        logic [39:0] b = 40'h00_0000_1000;
        do_start(b, 16'd8, 2'd1); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_start got=%0h/%0h exp=0/1", done, busy); end
        for (int c = 0; c < 10; c++) begin
            if (cmd_v) begin cmd_yumi = 1'b1; nis++; end else cmd_yumi = 1'b0;
            @(negedge clk); #1;
        end
        cmd_yumi = 1'b0;
        checks++; if (nis != 4) begin failures++; $display("FAIL bp_limit got=%0d exp=4", nis); end
        checks++; if (cmd_v !== 1'b0) begin failures++; $display("FAIL bp_stall got=%0h exp=0", cmd_v); end
        resp_v = 1'b1; resp_data = 64'hA0; #1;
        checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'd0 || spm_data !== 64'hA0 || cmd_v !== 1'b0)
            begin failures++; $display("FAIL bp_first_resp got=%0h/%0d/%h/%0h exp=1/0/a0/0", spm_w_v, spm_addr, spm_data, cmd_v); end
        @(negedge clk); resp_v = 1'b0; #1;
        checks++; if (cmd_v !== 1'b1 || cmd_addr !== 40'h00_0000_1020) begin failures++; $display("FAIL bp_refill got=%0h/%h exp=1/1020", cmd_v, cmd_addr); end
        cmd_yumi = 1'b1; nis = 5;
        @(negedge clk); cmd_yumi = 1'b0; #1;
        checks++; if (cmd_v !== 1'b0) begin failures++; $display("FAIL bp_refull got=%0h exp=0", cmd_v); end
        @(negedge clk);
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            resp_v = (outs > 0); resp_data = 64'hA0 + 64'(nrc);
            #1;
            if (cmd_v) begin
                checks++; if (outs >= 4 || cmd_addr !== b + 40'(nis * 8)) begin failures++; $display("FAIL bp_drain_addr got=%h exp=%h outs=%0d", cmd_addr, b + 40'(nis * 8), outs); end
                cmd_yumi = 1'b1; nis++; outs++;
            end else begin
                cmd_yumi = 1'b0;
            end
            if (resp_v) begin
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'(nrc) || spm_data !== 64'hA0 + 64'(nrc))
                    begin failures++; $display("FAIL bp_write got=%0h/%0d/%h exp=1/%0d", spm_w_v, spm_addr, spm_data, nrc); end
                nrc++; outs--;
            end
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        cmd_yumi = 1'b0; resp_v = 1'b0;
        checks++; if (!fin || nis != 8 || nrc != 8) begin failures++; $display("FAIL bp_complete got=%0d/%0d/%0d exp=1/8/8", fin, nis, nrc); end
    endtask

    task automatic test_zero_len;
        do_start(40'h00_0000_5000, 16'd0, 2'd0); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd_v !== 1'b0) begin failures++; $display("FAIL zero_done got=%0h/%0h/%0h exp=1/0/0", done, busy, cmd_v); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b1 || cmd_v !== 1'b0) begin failures++; $display("FAIL zero_after got=%0h/%0h exp=1/0", done, cmd_v); end
    endtask

    task automatic test_reset_mid;
        int due_q[$];
        int nis = 0, nrc = 0;
        bit fin = 1'b0;
        do_start(40'h00_0000_2000, 16'd6, 2'd1);
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front()); resp_v = 1'b1; resp_data = 64'h20 + 64'(nrc);
            end else begin
                resp_v = 1'b0;
            end
            #1;
            if (cmd_v) begin cmd_yumi = 1'b1; due_q.push_back(cyc + 2); nis++; end else cmd_yumi = 1'b0;
            if (resp_v) begin
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'(nrc)) begin failures++; $display("FAIL rmid_write got=%0h/%0d exp=1/%0d", spm_w_v, spm_addr, nrc); end
                nrc++;
            end
            if (nrc == 2) fin = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1; cmd_yumi = 1'b0; resp_v = 1'b0; #1;
        checks++; if (busy !== 1'b0 || cmd_v !== 1'b0 || done !== 1'b0 || cmd_addr !== 40'd0)
            begin failures++; $display("FAIL rmid_reset got=%0h/%0h/%0h/%h exp=0/0/0/0", busy, cmd_v, done, cmd_addr); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            resp_v = 1'b1; resp_data = 64'hDEAD; #1;
            checks++; if (spm_w_v !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_stray got=%0h/%0h exp=0/0", spm_w_v, busy); end
            @(negedge clk);
        end
        resp_v = 1'b0;
        nis = 0; nrc = 0; fin = 1'b0;
        do_start(40'h00_0000_3000, 16'd2, 2'd3);
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            resp_v = (nis > nrc); resp_data = 64'h51 + 64'(nrc);
            #1;
            if (cmd_v) begin
                checks++; if (cmd_addr !== 40'h00_0000_3000 + 40'(nis * 8)) begin failures++; $display("FAIL rmid_new_addr got=%h exp=%h", cmd_addr, 40'h00_0000_3000 + 40'(nis * 8)); end
                cmd_yumi = 1'b1; nis++;
            end else begin
                cmd_yumi = 1'b0;
            end
            if (resp_v) begin
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'(nrc) || spm_data !== 64'h51 + 64'(nrc) || spm_sel_o !== 2'd3)
                    begin failures++; $display("FAIL rmid_new_write got=%0h/%0d/%h/%0d exp=1/%0d", spm_w_v, spm_addr, spm_data, spm_sel_o, nrc); end
                nrc++;
            end
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        cmd_yumi = 1'b0; resp_v = 1'b0;
        checks++; if (!fin || nis != 2 || nrc != 2) begin failures++; $display("FAIL rmid_new_complete got=%0d/%0d/%0d exp=1/2/2", fin, nis, nrc); end
    endtask

    task automatic test_back_to_back;
        int due_q[$];
        int nis = 0, nrc = 0;
        bit fin = 1'b0;
        logic exp_v;
        do_start(40'h00_0000_4000, 16'd16, 2'd0);
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front()); resp_v = 1'b1; resp_data = 64'h100 + 64'(nrc);
            end else begin
                resp_v = 1'b0;
            end
            #1;
            exp_v = (cyc < 16);
            checks++; if (cmd_v !== exp_v) begin failures++; $display("FAIL b2b_cmd_v got=%0h exp=%0h cyc=%0d", cmd_v, exp_v, cyc); end
            if (cmd_v) begin cmd_yumi = 1'b1; due_q.push_back(cyc + 3); nis++; end else cmd_yumi = 1'b0;
            if (resp_v) begin
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'(nrc) || spm_data !== 64'h100 + 64'(nrc))
                    begin failures++; $display("FAIL b2b_write got=%0h/%0d/%h exp=1/%0d", spm_w_v, spm_addr, spm_data, nrc); end
                nrc++;
            end
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        cmd_yumi = 1'b0; resp_v = 1'b0;
        checks++; if (!fin || nis != 16 || nrc != 16) begin failures++; $display("FAIL b2b_complete got=%0d/%0d/%0d exp=1/16/16", fin, nis, nrc); end
    endtask

`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
    task automatic test_bounds;
        bit fin = 1'b0;
        int nrc = 0;
        do_start(40'h00_0000_6000, 16'd4097, 2'd1); #1;
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bounds_error got=%0h/%0h exp=1/0", error, busy); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (cmd_v !== 1'b0) begin failures++; $display("FAIL bounds_no_cmd got=%0h exp=0", cmd_v); end
            @(negedge clk); #1;
        end
        do_start(40'h00_0000_6000, 16'd1, 2'd1); #1;
        checks++; if (error !== 1'b0 || busy !== 1'b1 || cmd_v !== 1'b1) begin failures++; $display("FAIL bounds_clear got=%0h/%0h/%0h exp=0/1/1", error, busy, cmd_v); end
        cmd_yumi = 1'b1;
        @(negedge clk); cmd_yumi = 1'b0;
        for (int cyc = 0; cyc < 10 && !fin; cyc++) begin
            resp_v = (nrc == 0); resp_data = 64'h77; #1;
            if (resp_v) begin
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'd0 || spm_data !== 64'h77) begin failures++; $display("FAIL bounds_write got=%0h/%0d/%h exp=1/0/77", spm_w_v, spm_addr, spm_data); end
                nrc++;
            end
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        resp_v = 1'b0;
        checks++; if (!fin) begin failures++; $display("FAIL bounds_timeout got=0 exp=1"); end
    endtask
`else
    task automatic test_wrap;
        int nis = 0, nrc = 0;
        bit fin = 1'b0;
        logic [39:0] b = 40'hFF_FFFF_F000;
        do_start(b, 16'd4097, 2'd2);
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            resp_v = (nis > nrc); resp_data = 64'(nrc) ^ 64'hC0DE;
            #1;
            if (cmd_v) begin
                checks++; if (cmd_addr !== b + 40'(nis * 8)) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", cmd_addr, b + 40'(nis * 8)); end
                cmd_yumi = 1'b1; nis++;
            end else begin
                cmd_yumi = 1'b0;
            end
            if (resp_v) begin
                checks++; if (spm_w_v !== 1'b1 || spm_addr !== 12'(nrc) || spm_data !== (64'(nrc) ^ 64'hC0DE))
                    begin failures++; $display("FAIL wrap_write got=%0h/%0d/%h exp=1/%0d n=%0d", spm_w_v, spm_addr, spm_data, 12'(nrc), nrc); end
                nrc++;
            end
            if (done) fin = 1'b1;
            @(negedge clk);
        end
        cmd_yumi = 1'b0; resp_v = 1'b0;
        checks++; if (!fin || nis != 4097 || nrc != 4097) begin failures++; $display("FAIL wrap_complete got=%0d/%0d/%0d exp=1/4097/4097", fin, nis, nrc); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_zero_len;
        test_reset_mid;
        test_back_to_back;
`ifdef BP_SACC_DMA_BOUNDS_CHECK_EN
        test_bounds;
`else
        test_wrap;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
